// File: rtl/fifo_pkg.sv
// Shared definitions for the parameterised synchronous FIFO.
//   fifo_cw()      : width needed to index/count n values (minimum 1 bit)
//   FLAG_*         : bit positions inside the registered status-flag vector
package fifo_pkg;

  localparam int unsigned FLAG_FULL   = 0;
  localparam int unsigned FLAG_EMPTY  = 1;
  localparam int unsigned FLAG_AFULL  = 2;
  localparam int unsigned FLAG_AEMPTY = 3;
  localparam int unsigned FLAG_W      = 4;

  // Bits needed to encode values 0..n-1; never less than one bit.
  function automatic int unsigned fifo_cw(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH wrapping pointer with enable (works for non-power-of-2 DEPTH).
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset, clears pointer to 0
//   en_i     : advance the pointer this cycle
//   ptr_o    : current pointer value, 0..DEPTH-1
module fifo_ptr_ctr #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: wrap explicitly at DEPTH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered read data and status flags.
// Optional sticky error flags are enabled by defining PARAM_SYNC_FIFO_ERR_EN.
// Ports:
//   clk, reset_n          : clock (rising edge), synchronous active-low reset
//   push, data_in         : write request and write data
//   pop                   : read request
//   data_out, data_valid  : read word, valid for the one cycle after an accepted pop
//   full, empty           : occupancy == DEPTH / == 0
//   almost_full           : count >= AFULL_THRESH
//   almost_empty          : count <= AEMPTY_THRESH
//   overflow, underflow   : sticky push-while-full / pop-while-empty (macro only)
//   count                 : occupancy, clog2(DEPTH+1) bits
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned CW           = fifo_cw(DEPTH + 1),
  localparam int unsigned PW           = fifo_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
`ifdef PARAM_SYNC_FIFO_ERR_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [CW-1:0]    count
);

  // Parameter range checks at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("param_sync_fifo: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic [CW-1:0]     count_q,      count_d;
  logic [FLAG_W-1:0] status_q,     status_d;
  logic [WIDTH-1:0]  data_out_q,   data_out_d;
  logic              data_valid_q, data_valid_d;

  logic              push_acc_c;
  logic              pop_acc_c;

  // Acceptance uses registered flags only; full+push+pop pops but drops the push.
  assign push_acc_c = push & ~status_q[FLAG_FULL];
  assign pop_acc_c  = pop  & ~status_q[FLAG_EMPTY];

  fifo_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (push_acc_c),
    .ptr_o   (wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (pop_acc_c),
    .ptr_o   (rd_ptr)
  );

  // Storage is not reset; reset discards contents by clearing pointers/count.
  always_ff @(posedge clk) begin
    if (push_acc_c) mem_q[wr_ptr] <= data_in;
  end

  // Next count, flags (computed from the next count so they register alongside it) and read data.
  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    status_d     = '0;

    case ({push_acc_c, pop_acc_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_acc_c) begin
      data_out_d   = mem_q[rd_ptr];
      data_valid_d = 1'b1;
    end

    status_d[FLAG_FULL]   = (count_d == CW'(DEPTH));
    status_d[FLAG_EMPTY]  = (count_d == '0);
    status_d[FLAG_AFULL]  = (count_d >= CW'(AFULL_THRESH));
    status_d[FLAG_AEMPTY] = (count_d <= CW'(AEMPTY_THRESH));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q                <= '0;
      data_out_q             <= '0;
      data_valid_q           <= 1'b0;
      status_q               <= '0;
      status_q[FLAG_EMPTY]   <= 1'b1;
      status_q[FLAG_AEMPTY]  <= 1'b1;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      status_q     <= status_d;
    end
  end

`ifdef PARAM_SYNC_FIFO_ERR_EN
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset; push+pop while full still counts as an overflow.
  always_comb begin
    overflow_d  = overflow_q  | (push & status_q[FLAG_FULL]);
    underflow_d = underflow_q | (pop  & status_q[FLAG_EMPTY]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  assign count        = count_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign full         = status_q[FLAG_FULL];
  assign empty        = status_q[FLAG_EMPTY];
  assign almost_full  = status_q[FLAG_AFULL];
  assign almost_empty = status_q[FLAG_AEMPTY];

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 8: entry count, any integer >=2 (power of 2 not required).
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-2: almost_full level, range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2: almost_empty level, range 0..DEPTH-1.
REQ-005 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have ports: reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: push  in  1  write request; data_in  in  WIDTH  write data.
REQ-008 SHALL have ports: pop  in  1  read request; data_out  out  WIDTH  read data; data_valid  out  1  data_out updated this cycle.
REQ-009 SHALL have ports: full, empty, almost_full, almost_empty  out  1 each  status flags; count  out  CW  occupancy, CW = clog2(DEPTH+1).
REQ-010 SHALL have ports, when PARAM_SYNC_FIFO_ERR_EN is defined: overflow, underflow  out  1 each  sticky error flags.

Function
REQ-011 SHALL accept push iff push=1 and full=0; the accepted word is written at wr_ptr, which then advances.
REQ-012 SHALL accept pop iff pop=1 and empty=0; no bypass, so push+pop while empty accepts only the push.
REQ-013 SHALL handle push+pop while full by accepting the pop and rejecting the push (count decrements by 1).
REQ-014 SHALL keep count unchanged when push and pop are both accepted in the same cycle.
REQ-015 SHALL, on an accepted pop, drive data_out with the word at rd_ptr on the next cycle, with data_valid=1 for exactly that cycle.
REQ-016 SHALL hold data_out unchanged when no pop is accepted, with data_valid=0.
REQ-017 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0 (modulo DEPTH, including non-power-of-2 DEPTH).
REQ-018 SHALL hold count as a register; full=(count==DEPTH), empty=(count==0), almost_full=(count>=AFULL_THRESH), almost_empty=(count<=AEMPTY_THRESH).
REQ-019 SHALL derive all flags from registered state only, with no combinational path from push/pop.
REQ-020 SHALL preserve FIFO ordering across any number of pointer wraps.
REQ-021 SHALL leave storage, pointers and count unchanged on rejected requests.

Reset
REQ-022 SHALL, while reset_n=0 at a rising edge, set: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_valid=0, data_out=0, overflow=0, underflow=0.
REQ-023 SHALL not reset the storage array; reset asserted mid-operation discards all contents, and the FIFO reads empty on the next cycle.
REQ-024 SHALL give reset priority over simultaneous push/pop.

Configuration
REQ-025 SHALL, with PARAM_SYNC_FIFO_ERR_EN defined: set overflow on push while full, set underflow on pop while empty, and hold both until reset.
REQ-026 SHALL, without PARAM_SYNC_FIFO_ERR_EN: omit the overflow/underflow ports and logic, with all other behaviour identical.

Structure
REQ-027 SHALL place in shared package fifo_pkg: a clog2-based width function for pointers and count, and status-flag bit index constants.
REQ-028 SHALL implement each pointer as an instance of sub-module fifo_ptr_ctr (modulo-DEPTH wrapping counter with enable), instantiated twice.
REQ-029 SHALL fail elaboration for out-of-range DEPTH, AFULL_THRESH or AEMPTY_THRESH.

Verification (DEPTH=5, WIDTH=8, AFULL=3, AEMPTY=2, macro defined)
REQ-030 SHALL cover fill: push 0x01..0x05 -> count 1..5; almost_empty drops at count 3; almost_full rises at count 3; full=1 after 5th push.
REQ-031 SHALL cover drain: pop x5 from full -> data_out 0x01..0x05, each one cycle after its pop with data_valid=1; empty=1 after the last.
REQ-032 SHALL cover wrap: 4 rounds of push 3 / pop 3 -> ordering exact across index 4->0, count returns to 0 each round.
REQ-033 SHALL cover full push+pop: push+pop at count 5 -> count 4, oldest word out, pushed word dropped, overflow=1 and stays 1.
REQ-034 SHALL cover empty pop: pop alone when empty -> data_valid=0, underflow=1; push+pop when empty -> count 1, data_valid=0.
REQ-035 SHALL cover mid-op reset: reset_n=0 for 1 cycle at count 3 -> count 0, empty=1, data_valid=0, errors cleared; the next push/pop round-trips correctly.
